seg7_update_ctrl: RTL and testbench

//  Sequencer/arbiter for the 4-digit 7-seg device bus (adrs/we/from_cpu).

---
 rtl/seg7_update_ctrl.sv | 111 +++++++++++
 tb/tb_seg7_update_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_update_ctrl.sv
// seg7_update_ctrl
// Writes a 16-bit value, one nibble per digit, to the four HEX registers of
// the 7-segment device. The sequencer shares the device bus with the CPU and
// always yields to it. When auto_en is set, the last accepted value is
// rewritten periodically.
module seg7_update_ctrl #(
  parameter logic [15:0] BASE_ADRS   = 16'h0100,
  parameter logic [15:0] REFRESH_CYC = 16'd50000
) (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [15:0] cpu_adrs,
  input  logic        cpu_we,
  input  logic [15:0] cpu_from,
  input  logic        start,
  input  logic [15:0] value,
  input  logic        auto_en,
  output logic        busy,
  output logic        done,
  output logic [15:0] adrs,
  output logic        we,
  output logic [15:0] from_cpu
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  logic [1:0]  idx_reg;
  logic [15:0] val_reg;
  logic [15:0] refresh_cnt_reg;
  logic        refresh_tick;
  logic        seq_drive;

  // The refresh interval expires on the last count of the period.
  assign refresh_tick = auto_en && (refresh_cnt_reg == (REFRESH_CYC - 16'd1));

  // The sequencer owns the bus only while writing and only when the CPU is silent.
  assign seq_drive = (state_reg == WR) && !cpu_req;

  // Sequencer FSM with registered busy/done and the refresh interval counter.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      idx_reg         <= 2'd0;
      val_reg         <= 16'h0000;
      refresh_cnt_reg <= 16'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            // An explicit request beats a coincident refresh tick.
            val_reg         <= value;
            idx_reg         <= 2'd0;
            busy            <= 1'b1;
            state_reg       <= WR;
            refresh_cnt_reg <= 16'd0;
          end else if (!auto_en) begin
            refresh_cnt_reg <= 16'd0;
          end else if (refresh_tick) begin
            // Rewrite the previously latched value.
            idx_reg         <= 2'd0;
            busy            <= 1'b1;
            state_reg       <= WR;
            refresh_cnt_reg <= 16'd0;
          end else begin
            refresh_cnt_reg <= refresh_cnt_reg + 16'd1;
          end
        end
        WR: begin
          // A CPU access stalls the sequence; idx and the latch are held.
          if (!cpu_req) begin
            if (idx_reg == 2'd3) begin
              state_reg <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              idx_reg <= idx_reg + 2'd1;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Device bus mux: CPU passthrough unless the sequencer holds a write grant.
  always_comb begin
    adrs     = cpu_adrs;
    we       = cpu_we;
    from_cpu = cpu_from;
    if (seq_drive) begin
      adrs     = BASE_ADRS + {14'd0, idx_reg};
      we       = 1'b1;
      from_cpu = {12'h000, val_reg[{idx_reg, 2'b00} +: 4]};
    end
  end

endmodule

// File: tb/tb_seg7_update_ctrl.sv
// Testbench for seg7_update_ctrl. Each cycle the bench compares the bundle
// {busy, done, we, adrs, from_cpu} against what the update rules predict.
module tb_seg7_update_ctrl;

  localparam logic [15:0] BASE   = 16'h0100;
  localparam logic [15:0] BASE_W = 16'hFFFE;
  localparam int          RCYC   = 8;

  logic        cpu_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic [15:0] cpu_adrs = 16'h0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_from = 16'h0;
  logic        start = 1'b0;
  logic [15:0] value = 16'h0;
  logic        auto_en = 1'b0;
  logic        busy, done, we;
  logic [15:0] adrs, from_cpu;
  logic        busy_w, done_w, we_w;
  logic [15:0] adrs_w, from_w;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef logic [34:0] bus_t;

  seg7_update_ctrl #(.BASE_ADRS(BASE), .REFRESH_CYC(16'(RCYC))) dut (
    .cpu_clk(cpu_clk), .rst(rst), .cpu_req(cpu_req), .cpu_adrs(cpu_adrs),
    .cpu_we(cpu_we), .cpu_from(cpu_from), .start(start), .value(value),
    .auto_en(auto_en), .busy(busy), .done(done), .adrs(adrs), .we(we),
    .from_cpu(from_cpu)
  );

  // Second instance near the top of the address space for the wrap case.
  seg7_update_ctrl #(.BASE_ADRS(BASE_W), .REFRESH_CYC(16'(RCYC))) dut_w (
    .cpu_clk(cpu_clk), .rst(rst), .cpu_req(cpu_req), .cpu_adrs(cpu_adrs),
    .cpu_we(cpu_we), .cpu_from(cpu_from), .start(start), .value(value),
    .auto_en(auto_en), .busy(busy_w), .done(done_w), .adrs(adrs_w), .we(we_w),
    .from_cpu(from_w)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Expected bundle when the CPU inputs pass straight through.
  function automatic bus_t pass_b(input logic b, input logic d);
    return {b, d, cpu_we, cpu_adrs, cpu_from};
  endfunction

  // Expected bundle for a sequencer write of digit k of v.
  function automatic bus_t wr_b(input logic [15:0] base, input int k, input logic [15:0] v);
    logic [15:0] a;
    logic [15:0] nib;
    a   = base + 16'(k);
    nib = (v >> (4 * k)) & 16'h000F;
    return {1'b1, 1'b0, 1'b1, a, nib};
  endfunction

  task automatic next_cycle();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic rand_cpu(input logic req);
    cpu_req  = req;
    cpu_adrs = 16'($urandom);
    cpu_we   = 1'($urandom);
    cpu_from = 16'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; auto_en = 1'b0;
    rand_cpu(1'b0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus_t obs, exp;
    rst = 1'b1; start = 1'b1; value = 16'hBEEF; auto_en = 1'b0;
    rand_cpu(1'b0);
    next_cycle();
    next_cycle();
    rst = 1'b0; start = 1'b0; auto_en = 1'b1;
    // Latch resets to zero, so the first refresh writes zeros.
    for (int c = 0; c < RCYC + 6; c++) begin
      rand_cpu(1'b0);
      #1;
      if (c < RCYC) exp = pass_b(1'b0, 1'b0);
      else if (c < RCYC + 4) exp = wr_b(BASE, c - RCYC, 16'h0000);
      else if (c == RCYC + 4) exp = pass_b(1'b0, 1'b1);
      else exp = pass_b(1'b0, 1'b0);
      obs = {busy, done, we, adrs, from_cpu};
      total_cnt++;
      if (obs !== exp) $display("FAIL reset cyc%0d got %h exp %h", c, obs, exp);
      else pass_cnt++;
      next_cycle();
    end
    auto_en = 1'b0;
  endtask

  task automatic test_basic();
    bus_t obs, exp;
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      rand_cpu(1'b0);
      start = (c == 0);
      value = 16'hA5C3;
      #1;
      if (c == 0) exp = pass_b(1'b0, 1'b0);
      else if (c <= 4) exp = wr_b(BASE, c - 1, 16'hA5C3);
      else if (c == 5) exp = pass_b(1'b0, 1'b1);
      else exp = pass_b(1'b0, 1'b0);
      obs = {busy, done, we, adrs, from_cpu};
      total_cnt++;
      if (obs !== exp) $display("FAIL basic cyc%0d got %h exp %h", c, obs, exp);
      else pass_cnt++;
      next_cycle();
    end
    start = 1'b0;
  endtask

  task automatic test_cpu_stall();
    bus_t obs, exp;
    int k;
    k = 0;
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      rand_cpu(c == 2 || c == 3);
      start = (c == 0);
      value = 16'hA5C3;
      #1;
      if (c == 0 || c == 8) exp = pass_b(1'b0, 1'b0);
      else if (c == 7) exp = pass_b(1'b0, 1'b1);
      else if (cpu_req) exp = pass_b(1'b1, 1'b0);
      else begin
        exp = wr_b(BASE, k, 16'hA5C3);
        k++;
      end
      obs = {busy, done, we, adrs, from_cpu};
      total_cnt++;
      if (obs !== exp) $display("FAIL stall cyc%0d got %h exp %h", c, obs, exp);
      else pass_cnt++;
      next_cycle();
    end
    start = 1'b0;
  endtask

  task automatic test_start_while_busy();
    bus_t obs, exp;
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      rand_cpu(1'b0);
      start = (c <= 5);
      value = (c == 0) ? 16'h1234 : 16'hFFFF;
      #1;
      if (c == 0 || c >= 6) exp = pass_b(1'b0, 1'b0);
      else if (c <= 4) exp = wr_b(BASE, c - 1, 16'h1234);
      else exp = pass_b(1'b0, 1'b1);
      obs = {busy, done, we, adrs, from_cpu};
      total_cnt++;
      if (obs !== exp) $display("FAIL busy_start cyc%0d got %h exp %h", c, obs, exp);
      else pass_cnt++;
      next_cycle();
    end
    start = 1'b0;
  endtask

  task automatic test_refresh();
    bus_t obs, exp;
    int p;
    do_reset();
    // Initial update of 00F1 with refresh disabled.
    for (int c = 0; c <= 5; c++) begin
      rand_cpu(1'b0);
      start = (c == 0);
      value = 16'h00F1;
      next_cycle();
    end
    start = 1'b0;
    value = 16'h7777;
    auto_en = 1'b1;
    // Period: 8 idle cycles, 4 writes, 1 done cycle.
    for (int c = 0; c < 2 * (RCYC + 5); c++) begin
      rand_cpu(1'b0);
      #1;
      p = c % (RCYC + 5);
      if (p < RCYC) exp = pass_b(1'b0, 1'b0);
      else if (p < RCYC + 4) exp = wr_b(BASE, p - RCYC, 16'h00F1);
      else exp = pass_b(1'b0, 1'b1);
      obs = {busy, done, we, adrs, from_cpu};
      total_cnt++;
      if (obs !== exp) $display("FAIL refresh cyc%0d got %h exp %h", c, obs, exp);
      else pass_cnt++;
      next_cycle();
    end
    auto_en = 1'b0;
  endtask

  task automatic test_reset_abort();
    bus_t obs, exp;
    do_reset();
    for (int c = 0; c <= 2; c++) begin
      rand_cpu(1'b0);
      start = (c == 0);
      value = 16'h5A69;
      #1;
      exp = (c == 0) ? pass_b(1'b0, 1'b0) : wr_b(BASE, c - 1, 16'h5A69);
      obs = {busy, done, we, adrs, from_cpu};
      total_cnt++;
      if (obs !== exp) $display("FAIL abort_pre cyc%0d got %h exp %h", c, obs, exp);
      else pass_cnt++;
      next_cycle();
    end
    start = 1'b0;
    rst = 1'b1;
    rand_cpu(1'b0);
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      rand_cpu(1'($urandom));
      #1;
      exp = pass_b(1'b0, 1'b0);
      obs = {busy, done, we, adrs, from_cpu};
      total_cnt++;
      if (obs !== exp) $display("FAIL abort_post cyc%0d got %h exp %h", c, obs, exp);
      else pass_cnt++;
      next_cycle();
    end
    // A fresh start must begin at HEX0.
    rand_cpu(1'b0);
    start = 1'b1;
    value = 16'h4321;
    next_cycle();
    start = 1'b0;
    rand_cpu(1'b0);
    #1;
    exp = wr_b(BASE, 0, 16'h4321);
    obs = {busy, done, we, adrs, from_cpu};
    total_cnt++;
    if (obs !== exp) $display("FAIL abort_restart got %h exp %h", obs, exp);
    else pass_cnt++;
    for (int c = 0; c < 5; c++) next_cycle();
  endtask

  task automatic test_start_vs_tick();
    bus_t obs, exp;
    int p;
    do_reset();
    auto_en = 1'b1;
    // Tick falls on idle cycle RCYC-1; start is raised in that same cycle.
    for (int c = 0; c < RCYC; c++) begin
      rand_cpu(1'b0);
      start = (c == RCYC - 1);
      value = 16'h0BEE;
      #1;
      exp = pass_b(1'b0, 1'b0);
      obs = {busy, done, we, adrs, from_cpu};
      total_cnt++;
      if (obs !== exp) $display("FAIL tick_idle cyc%0d got %h exp %h", c, obs, exp);
      else pass_cnt++;
      next_cycle();
    end
    start = 1'b0;
    // Start sequence, then a full refresh period from a counter restarted at 0.
    for (int c = 0; c < 5 + RCYC + 5; c++) begin
      rand_cpu(1'b0);
      #1;
      p = (c < 5) ? c + RCYC : c - 5;
      if (p < RCYC) exp = pass_b(1'b0, 1'b0);
      else if (p < RCYC + 4) exp = wr_b(BASE, p - RCYC, 16'h0BEE);
      else exp = pass_b(1'b0, 1'b1);
      obs = {busy, done, we, adrs, from_cpu};
      total_cnt++;
      if (obs !== exp) $display("FAIL tick_seq cyc%0d got %h exp %h", c, obs, exp);
      else pass_cnt++;
      next_cycle();
    end
    auto_en = 1'b0;
  endtask

  task automatic test_addr_wrap();
    logic [31:0] obs, exp;
    bus_t e;
    do_reset();
    rand_cpu(1'b0);
    start = 1'b1;
    value = 16'h9876;
    next_cycle();
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      rand_cpu(1'b0);
      #1;
      e = wr_b(BASE_W, c, 16'h9876);
      exp = e[31:0];
      obs = {adrs_w, from_w};
      total_cnt++;
      if (obs !== exp) $display("FAIL addr_wrap cyc%0d got %h exp %h", c, obs, exp);
      else pass_cnt++;
      next_cycle();
    end
    next_cycle();
  endtask

  // Random CPU traffic and starts against a queue of pending digit writes.
  task automatic test_random();
    bus_t obs, exp;
    logic [31:0] q[$];
    logic done_due, new_done, idle, busy_e;
    logic [15:0] nib;
    done_due = 1'b0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rand_cpu($urandom_range(0, 2) == 0);
      start = ($urandom_range(0, 3) == 0);
      value = 16'($urandom);
      #1;
      busy_e = (q.size() != 0);
      if (q.size() != 0 && !cpu_req) exp = {busy_e, done_due, 1'b1, q[0]};
      else exp = pass_b(busy_e, done_due);
      obs = {busy, done, we, adrs, from_cpu};
      total_cnt++;
      if (obs !== exp) $display("FAIL random cyc%0d got %h exp %h", c, obs, exp);
      else pass_cnt++;
      idle = (q.size() == 0) && !done_due;
      new_done = 1'b0;
      if (q.size() != 0 && !cpu_req) begin
        void'(q.pop_front());
        if (q.size() == 0) new_done = 1'b1;
      end
      if (start && idle) begin
        for (int k = 0; k < 4; k++) begin
          nib = (value >> (4 * k)) & 16'h000F;
          q.push_back({BASE + 16'(k), nib});
        end
      end
      done_due = new_done;
      next_cycle();
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cpu_stall();
    test_start_while_busy();
    test_refresh();
    test_reset_abort();
    test_start_vs_tick();
    test_addr_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
